uart_module: RTL and testbench
==============================

# uart_module

Full-duplex 8N1 UART: one transmitter and one receiver sharing a programmable 16x-oversampling baud divisor. It sits between a CPU/register front end and the board TXD/RXD pins. Completion is reported through sticky flags that the host clears explicitly.

## Interface
Parameters: none (frame format fixed, see Structure).
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous reset, active-high: a 1 sampled on a clk edge resets the block. The port name is historical; the polarity is as stated here.
- baudselect  in  10  clk cycles per oversample tick; one bit = 16 ticks; value 0 treated as 1.
- tx_data  in  8  byte to transmit, latched at frame start.
- tx_start  in  1  level request to transmit.
- tx_complete_del_flag  in  1  clears tx_complete_flag.
- RXD  in  1  serial input, asynchronous, idles high.
- rx_complete_del_flag  in  1  clears rx_complete_flag.
- TXD  out  1  serial output, idles high.
- tx_busy  out  1  frame in progress.
- tx_complete_flag  out  1  sticky, set at end of each transmitted frame.
- rx_data  out  8  last correctly framed received byte.
- rx_complete_flag  out  1  sticky, set when rx_data is updated.

## Operation
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Baud divisor: baudselect is latched separately at each TX frame start and each RX start detection. Changes mid-frame have no effect until the next frame.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when tx_start=1, latch tx_data and baudselect and go to START. tx_start is level-sensitive; holding it high sends back-to-back frames.
  - Each state lasts 16 ticks; DATA repeats 8 times.
  - At the end of STOP: return to IDLE and set tx_complete_flag.
  - tx_start is ignored while busy.
- RX path: RXD passes through a 2-flop synchronizer.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge moves to START and restarts the tick counter.
  - START: sample at tick 8. If the line is high, the start was false: return to IDLE. If low, go to DATA.
  - DATA: sample each bit at 16-tick intervals (mid-bit).
  - STOP: sample at mid-bit. If high, load rx_data and set rx_complete_flag. If low (framing error), discard the byte and leave rx_data and the flag unchanged.
  - In both cases, return to IDLE only after the line is observed high.
- Overrun: a new good byte overwrites rx_data even if rx_complete_flag is still set.
- Flags: the del input clears its flag on the next edge. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: TXD=1, tx_busy=0, tx_complete_flag=0, rx_complete_flag=0, rx_data=0x00. Both FSMs go to IDLE and all counters are cleared.
- Reset mid-frame aborts the frame. TXD returns high on that edge and no flag is set.
- TX latency:
  - tx_start sampled in IDLE → TXD=0 and tx_busy=1 on the next edge.
  - Each bit lasts 16·baudselect cycles; the frame lasts 160·baudselect cycles.
  - tx_complete_flag=1 and tx_busy=0 on the same edge the stop bit ends.
- Example: baudselect=325 at 100 MHz gives 5200 cycles/bit (≈19230 baud) and 52000 cycles/frame.
- RX latency:
  - The synchronizer adds 2 cycles.
  - rx_data and rx_complete_flag update one cycle after the mid-stop-bit sample, about 9.5 bit times after the falling start edge.
- Start detection requires low at the mid-start sample. Glitches shorter than 8·baudselect cycles are rejected.

## Structure
- Package uart_pkg:
  - OVERSAMPLE=16, DATA_BITS=8, DIV_W=10.
  - Shared state enum {IDLE, START, DATA, STOP}.
- Sub-module uart_baud_gen: divisor counter producing a 1-cycle tick every baudselect cycles, with a synchronous restart input. One instance each for TX and RX.
- Top level contains the TX FSM with shift register, the RX FSM with synchronizer and shift register, and the flag logic.

## Test plan
- Reset: hold reset_n=1 for 5 cycles, then release → TXD=1, tx_busy=0, both flags 0, rx_data=0x00.
- TX byte: baudselect=325, tx_data=0x2F, tx_start pulsed 1 cycle →
  - TXD low for 5200 cycles, then bits 1,1,1,1,0,1,0,0, then high.
  - tx_complete_flag=1 and tx_busy=0 exactly 52000 cycles after TXD fell.
- Flag clear and priority: pulse tx_complete_del_flag → flag 0 next cycle. With tx_start held high, assert del in the same cycle a frame ends → flag stays 1 and the next frame starts immediately.
- RX byte: drive 0xA5 on RXD at 5200 cycles/bit → rx_data=0xA5, rx_complete_flag=1. Pulse rx_complete_del_flag → flag 0.
- RX errors:
  - 2000-cycle low glitch → no flag, FSM back in IDLE.
  - Frame 0x3C with stop bit low → rx_data and flag unchanged.
  - A following good 0x55 is received correctly.
- Reset mid-frame: assert reset_n during TX data bit 3 → TXD=1, tx_busy=0, no flag. A new tx_start sends a full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned DIV_W      = 10;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every divisor_i clocks (0 acts as 1).
// restart_i holds the phase at zero so the first tick lands divisor_i cycles later.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] DivOne = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_eff;

  // Divisor clamp, tick decode and next count.
  always_comb begin
    div_eff = (divisor_i == '0) ? DivOne : divisor_i;
    tick_o  = !restart_i && (cnt_q == div_eff - DivOne);
    cnt_d   = cnt_q + DivOne;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Divisor counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_module.sv
// Full-duplex 8N1 UART with sticky completion flags cleared by the host.
// reset_n is an active-high synchronous reset despite its name.
module uart_module
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] baudselect,
  input  logic [7:0]       tx_data,
  input  logic             tx_start,
  input  logic             tx_complete_del_flag,
  input  logic             RXD,
  input  logic             rx_complete_del_flag,
  output logic             TXD,
  output logic             tx_busy,
  output logic             tx_complete_flag,
  output logic [7:0]       rx_data,
  output logic             rx_complete_flag
);

  localparam logic [CNT_W-1:0] LastTick = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MidTick  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] LastBit  = BIT_W'(DATA_BITS - 1);

  // ---------------- Transmitter ----------------
  uart_state_e      tx_state_q;
  logic [DIV_W-1:0] tx_div_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [BIT_W-1:0] tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_tick;

  uart_baud_gen u_tx_baud (
    .clk_i     (clk),
    .rst_i     (reset_n),
    .restart_i (tx_state_q == StIdle),
    .divisor_i (tx_div_q),
    .tick_o    (tx_tick)
  );

  // TX FSM with registered TXD/busy and the set-wins completion flag.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      tx_state_q       <= StIdle;
      tx_div_q         <= '0;
      tx_cnt_q         <= '0;
      tx_bit_q         <= '0;
      tx_shift_q       <= '0;
      TXD              <= 1'b1;
      tx_busy          <= 1'b0;
      tx_complete_flag <= 1'b0;
    end else begin
      if (tx_complete_del_flag) begin
        tx_complete_flag <= 1'b0;
      end
      unique case (tx_state_q)
        StIdle: begin
          if (tx_start) begin
            tx_shift_q <= tx_data;
            tx_div_q   <= baudselect;
            tx_cnt_q   <= '0;
            tx_state_q <= StStart;
            TXD        <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end
        StStart: begin
          if (tx_tick) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_cnt_q == LastTick) begin
              tx_state_q <= StData;
              tx_bit_q   <= '0;
              TXD        <= tx_shift_q[0];
            end
          end
        end
        StData: begin
          if (tx_tick) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_cnt_q == LastTick) begin
              if (tx_bit_q == LastBit) begin
                tx_state_q <= StStop;
                TXD        <= 1'b1;
              end else begin
                tx_bit_q   <= tx_bit_q + 1'b1;
                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                TXD        <= tx_shift_q[1];
              end
            end
          end
        end
        StStop: begin
          if (tx_tick) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_cnt_q == LastTick) begin
              tx_state_q       <= StIdle;
              tx_busy          <= 1'b0;
              tx_complete_flag <= 1'b1;
            end
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  // ---------------- Receiver ----------------
  uart_state_e      rx_state_q;
  logic [DIV_W-1:0] rx_div_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [BIT_W-1:0] rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_wait_q;   // stop bit was low; waiting for line to return high
  logic             rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic             rx_tick;

  uart_baud_gen u_rx_baud (
    .clk_i     (clk),
    .rst_i     (reset_n),
    .restart_i (rx_state_q == StIdle),
    .divisor_i (rx_div_q),
    .tick_o    (rx_tick)
  );

  // RXD synchronizer plus previous-sample register for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  // RX FSM: mid-bit sampling, framing check and set-wins completion flag.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_state_q       <= StIdle;
      rx_div_q         <= '0;
      rx_cnt_q         <= '0;
      rx_bit_q         <= '0;
      rx_shift_q       <= '0;
      rx_wait_q        <= 1'b0;
      rx_data          <= '0;
      rx_complete_flag <= 1'b0;
    end else begin
      if (rx_complete_del_flag) begin
        rx_complete_flag <= 1'b0;
      end
      unique case (rx_state_q)
        StIdle: begin
          if (rxd_prev_q && !rxd_s2_q) begin
            rx_div_q   <= baudselect;
            rx_cnt_q   <= '0;
            rx_state_q <= StStart;
          end
        end
        StStart: begin
          if (rx_tick) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == MidTick) begin
              if (rxd_s2_q) begin
                rx_state_q <= StIdle;
              end else begin
                rx_state_q <= StData;
                rx_cnt_q   <= '0;
                rx_bit_q   <= '0;
              end
            end
          end
        end
        StData: begin
          if (rx_tick) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == LastTick) begin
              rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
              if (rx_bit_q == LastBit) begin
                rx_state_q <= StStop;
              end else begin
                rx_bit_q <= rx_bit_q + 1'b1;
              end
            end
          end
        end
        StStop: begin
          if (rx_wait_q) begin
            if (rxd_s2_q) begin
              rx_wait_q  <= 1'b0;
              rx_state_q <= StIdle;
            end
          end else if (rx_tick) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == LastTick) begin
              if (rxd_s2_q) begin
                rx_data          <= rx_shift_q;
                rx_complete_flag <= 1'b1;
                rx_state_q       <= StIdle;
              end else begin
                rx_wait_q <= 1'b1;
              end
            end
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_module.sv
// Directed self-checking bench for uart_module.
module tb_uart_module;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] baudselect = 10'd325;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_complete_del_flag = 1'b0;
  logic       RXD = 1'b1;
  logic       rx_complete_del_flag = 1'b0;
  logic       TXD, tx_busy, tx_complete_flag, rx_complete_flag;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_module dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .baudselect           (baudselect),
    .tx_data              (tx_data),
    .tx_start             (tx_start),
    .tx_complete_del_flag (tx_complete_del_flag),
    .RXD                  (RXD),
    .rx_complete_del_flag (rx_complete_del_flag),
    .TXD                  (TXD),
    .tx_busy              (tx_busy),
    .tx_complete_flag     (tx_complete_flag),
    .rx_data              (rx_data),
    .rx_complete_flag     (rx_complete_flag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int bc);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = f[i];
      repeat (bc) step();
    end
    RXD = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (5) step();
    reset_n = 1'b0;
    step();
    checks++;
    if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", TXD); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    checks++;
    if (tx_complete_flag !== 1'b0 || rx_complete_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got tx=%b rx=%b expected 0 0", tx_complete_flag,
               rx_complete_flag);
    end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rxdata: got %h expected 00", rx_data); end
  endtask

  // 0x2F at 5200 cycles/bit, checked every cycle of the 52000-cycle frame.
  task automatic test_tx_byte();
    logic [9:0] frame;
    int         bad[10];
    frame = {1'b1, 8'h2F, 1'b0};
    for (int b = 0; b < 10; b++) bad[b] = 0;
    baudselect = 10'd325;
    tx_data    = 8'h2F;
    tx_start   = 1'b1;
    step();
    tx_start = 1'b0;
    checks++;
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_start: got %b expected 1", tx_busy); end
    for (int n = 0; n < 52000; n++) begin
      if (TXD !== frame[n / 5200]) bad[n / 5200]++;
      if (n == 51999) begin
        checks++;
        if (tx_complete_flag !== 1'b0 || tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL tx_before_end: got flag=%b busy=%b expected 0 1", tx_complete_flag,
                   tx_busy);
        end
      end
      step();
    end
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (bad[b] != 0) begin
        errors++;
        $display("FAIL tx_bit%0d: %0d cycles wrong, expected level %b", b, bad[b], frame[b]);
      end
    end
    checks++;
    if (tx_complete_flag !== 1'b1 || tx_busy !== 1'b0 || TXD !== 1'b1) begin
      errors++;
      $display("FAIL tx_end: got flag=%b busy=%b txd=%b expected 1 0 1", tx_complete_flag,
               tx_busy, TXD);
    end
  endtask

  task automatic test_flag_clear();
    tx_complete_del_flag = 1'b1;
    step();
    tx_complete_del_flag = 1'b0;
    checks++;
    if (tx_complete_flag !== 1'b0) begin
      errors++;
      $display("FAIL tx_flag_clear: got %b expected 0", tx_complete_flag);
    end
  endtask

  // Clear coincides with the frame-ending edge; set must win. 320 cycles/frame.
  task automatic test_back_to_back();
    int waited;
    baudselect = 10'd2;
    tx_data    = 8'hC3;
    tx_start   = 1'b1;
    step();
    repeat (319) step();
    checks++;
    if (tx_complete_flag !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_before_end: got flag=%b busy=%b expected 0 1", tx_complete_flag, tx_busy);
    end
    tx_complete_del_flag = 1'b1;
    step();
    tx_complete_del_flag = 1'b0;
    checks++;
    if (tx_complete_flag !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_set_wins: got flag=%b busy=%b expected 1 0", tx_complete_flag, tx_busy);
    end
    step();
    checks++;
    if (tx_busy !== 1'b1 || TXD !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b txd=%b expected 1 0", tx_busy, TXD);
    end
    tx_start = 1'b0;
    waited = 0;
    while (tx_busy === 1'b1 && waited < 1000) begin
      step();
      waited++;
    end
    checks++;
    if (tx_busy !== 1'b0 || waited != 320) begin
      errors++;
      $display("FAIL b2b_second_len: got %0d cycles busy=%b expected 320 0", waited, tx_busy);
    end
    tx_complete_del_flag = 1'b1;
    step();
    tx_complete_del_flag = 1'b0;
  endtask

  // 0xA5 at 64 cycles/bit (baudselect=4).
  task automatic test_rx_byte();
    baudselect = 10'd4;
    send_rx(8'hA5, 1'b1, 64);
    repeat (4) step();
    checks++;
    if (rx_data !== 8'hA5 || rx_complete_flag !== 1'b1) begin
      errors++;
      $display("FAIL rx_a5: got data=%h flag=%b expected a5 1", rx_data, rx_complete_flag);
    end
    rx_complete_del_flag = 1'b1;
    step();
    rx_complete_del_flag = 1'b0;
    checks++;
    if (rx_complete_flag !== 1'b0) begin
      errors++;
      $display("FAIL rx_flag_clear: got %b expected 0", rx_complete_flag);
    end
  endtask

  task automatic test_rx_errors();
    RXD = 1'b0;
    repeat (20) step();
    RXD = 1'b1;
    repeat (200) step();
    checks++;
    if (rx_complete_flag !== 1'b0 || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL rx_glitch: got data=%h flag=%b expected a5 0", rx_data, rx_complete_flag);
    end
    send_rx(8'h3C, 1'b0, 64);
    repeat (20) step();
    checks++;
    if (rx_complete_flag !== 1'b0 || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL rx_framing: got data=%h flag=%b expected a5 0", rx_data, rx_complete_flag);
    end
    send_rx(8'h55, 1'b1, 64);
    repeat (4) step();
    checks++;
    if (rx_data !== 8'h55 || rx_complete_flag !== 1'b1) begin
      errors++;
      $display("FAIL rx_after_err: got data=%h flag=%b expected 55 1", rx_data, rx_complete_flag);
    end
    // Overrun: flag still set, new byte must overwrite.
    repeat (20) step();
    send_rx(8'h81, 1'b1, 64);
    repeat (4) step();
    checks++;
    if (rx_data !== 8'h81 || rx_complete_flag !== 1'b1) begin
      errors++;
      $display("FAIL rx_overrun: got data=%h flag=%b expected 81 1", rx_data, rx_complete_flag);
    end
  endtask

  // Reset during data bit 3 (frame bit index 4) at 32 cycles/bit.
  task automatic test_reset_mid_frame();
    logic [9:0] frame;
    int         bad;
    baudselect = 10'd2;
    tx_data    = 8'h96;
    tx_start   = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (140) step();
    reset_n = 1'b1;
    step();
    reset_n = 1'b0;
    checks++;
    if (TXD !== 1'b1 || tx_busy !== 1'b0 || tx_complete_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got txd=%b busy=%b flag=%b expected 1 0 0", TXD, tx_busy,
               tx_complete_flag);
    end
    checks++;
    if (rx_data !== 8'h00 || rx_complete_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rx: got data=%h flag=%b expected 00 0", rx_data, rx_complete_flag);
    end
    step();
    tx_data  = 8'h5A;
    frame    = {1'b1, 8'h5A, 1'b0};
    bad      = 0;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int n = 0; n < 320; n++) begin
      if (n % 32 == 16 && TXD !== frame[n / 32]) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_frame: got %0d bad bits expected 0", bad); end
    checks++;
    if (tx_complete_flag !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_end: got flag=%b busy=%b expected 1 0", tx_complete_flag, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_tx_byte();
    test_flag_clear();
    test_back_to_back();
    test_rx_byte();
    test_rx_errors();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
